// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode encodings, op classes and sequencer states shared by the matrix control decoders
package ctrl_pkg;
   localparam logic [5:0] OP_LOAD  = 6'b000000;
   localparam logic [5:0] OP_STORE = 6'b000001;
   localparam logic [5:0] OP_VEC0  = 6'b001000;
   localparam logic [5:0] OP_VEC1  = 6'b001001;
   localparam logic [5:0] OP_VEC2  = 6'b001101;
   localparam logic [5:0] OP_MMUL  = 6'b001100;
   localparam logic [2:0] OP_INT_HI  = 3'b010;
   localparam logic [4:0] OP_CMP_HI  = 5'b01100;
   localparam logic [3:0] OP_JUMP_HI = 4'b0111;
   localparam logic [5:0] OP_ZERO  = 6'b100100;

   typedef enum logic [3:0] {
      CL_LOAD, CL_STORE, CL_VEC, CL_MMUL, CL_INT, CL_CMP, CL_JUMP, CL_ZERO, CL_ILLEGAL
   } opClass_t;

   typedef enum logic [2:0] {
      S_IDLE, S_MEM, S_LANE, S_EXEC, S_WB, S_DONE
   } state_t;

   function automatic int atLeastOne(int w);
      return w < 1 ? 1 : w;
   endfunction
endpackage

// File: rtl/matrix_ctrl_seq_op_class_decode.sv
// op_class_decode: combinational opcode to op-class mapping
module op_class_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   output opClass_t   opClass
);
   assign opClass = op == OP_LOAD                                ? CL_LOAD  :
                    op == OP_STORE                               ? CL_STORE :
                    op == OP_VEC0 || op == OP_VEC1 || op == OP_VEC2 ? CL_VEC   :
                    op == OP_MMUL                                ? CL_MMUL  :
                    op[5:3] == OP_INT_HI                         ? CL_INT   :
                    op[5:1] == OP_CMP_HI                         ? CL_CMP   :
                    op[5:2] == OP_JUMP_HI                        ? CL_JUMP  :
                    op == OP_ZERO                                ? CL_ZERO  : CL_ILLEGAL;
endmodule

// File: rtl/matrix_ctrl_seq.sv
// matrix_ctrl_seq: multi-cycle opcode sequencer driving memory, lane and register-file strobes
module matrix_ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int MUL_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             mem_ready,
   output logic             inst_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic [LANES-1:0] data_out,
   output logic             reg_write,
   output logic             flag_write,
   output logic             done,
   output logic             illegal,
   output logic             timeout
);
   localparam int LW = $clog2(LANES);
   localparam int SW = atLeastOne($clog2(MUL_CYCLES));
   localparam int WW = atLeastOne($clog2(MEM_TIMEOUT + 1));
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [SW-1:0] LAST_SUB  = SW'(MUL_CYCLES - 1);
   localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_TIMEOUT - 1);
   localparam logic [LANES-1:0] LANE0 = LANES'(1);
   localparam logic [LANES-1:0] ALL   = {LANES{1'b1}};

   state_t           state;
   opClass_t         cls;
   opClass_t         decCls;
   logic [LW-1:0]    laneIdx;
   logic [LW-1:0]    nextLane;
   logic [SW-1:0]    subCnt;
   logic [SW-1:0]    nextSub;
   logic [WW-1:0]    waitCnt;
   logic             lastSub;
   logic             lastLane;
   logic             waitHit;

   op_class_decode uDecode (.op(op), .opClass(decCls));

   assign nextLane = laneIdx + 1'b1;
   assign nextSub  = subCnt + 1'b1;
   assign lastSub  = cls == CL_VEC || subCnt == LAST_SUB;
   assign lastLane = laneIdx == LAST_LANE;
   assign waitHit  = MEM_TIMEOUT != 0 && waitCnt == LAST_WAIT;

   // Advance the sequencer and register the outputs belonging to the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cls        <= CL_ILLEGAL;
         laneIdx    <= '0;
         subCnt     <= '0;
         waitCnt    <= '0;
         op_ready   <= 1'b1;
         inst_write <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         data_out   <= '0;
         reg_write  <= 1'b0;
         flag_write <= 1'b0;
         done       <= 1'b0;
         illegal    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         op_ready   <= 1'b0;
         inst_write <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         data_out   <= '0;
         reg_write  <= 1'b0;
         flag_write <= 1'b0;
         done       <= 1'b0;
         illegal    <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            S_IDLE: if (op_valid) begin
               cls     <= decCls;
               laneIdx <= '0;
               subCnt  <= '0;
               waitCnt <= '0;
               case (decCls)
                  CL_LOAD, CL_STORE: begin
                     state      <= S_MEM;
                     inst_write <= 1'b1;
                     mem_read   <= decCls == CL_LOAD;
                     mem_write  <= decCls == CL_STORE;
                  end
                  CL_VEC, CL_MMUL: begin
                     state     <= S_LANE;
                     data_out  <= LANE0;
                     reg_write <= decCls == CL_VEC || MUL_CYCLES == 1;
                  end
                  CL_INT, CL_CMP: begin
                     state      <= S_EXEC;
                     reg_write  <= decCls == CL_INT;
                     flag_write <= decCls == CL_CMP;
                  end
                  CL_ZERO: begin
                     state     <= S_WB;
                     data_out  <= ALL;
                     reg_write <= 1'b1;
                  end
                  default: begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     illegal <= decCls == CL_ILLEGAL;
                  end
               endcase
            end else begin
               op_ready <= 1'b1;
            end
            S_MEM: if (mem_ready) begin
               state     <= cls == CL_LOAD ? S_WB : S_DONE;
               data_out  <= cls == CL_LOAD ? ALL : '0;
               reg_write <= cls == CL_LOAD;
               done      <= cls != CL_LOAD;
            end else if (waitHit) begin
               state   <= S_DONE;
               done    <= 1'b1;
               timeout <= 1'b1;
            end else begin
               waitCnt    <= waitCnt + 1'b1;
               inst_write <= 1'b1;
               mem_read   <= cls == CL_LOAD;
               mem_write  <= cls == CL_STORE;
            end
            S_LANE: if (!lastSub) begin
               subCnt    <= nextSub;
               data_out  <= LANE0 << laneIdx;
               reg_write <= nextSub == LAST_SUB;
            end else if (!lastLane) begin
               laneIdx   <= nextLane;
               subCnt    <= '0;
               data_out  <= LANE0 << nextLane;
               reg_write <= cls == CL_VEC || MUL_CYCLES == 1;
            end else begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_EXEC, S_WB: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
